bp_cce_inst_fetch_pred: RTL and testbench

- Next-generation CCE instruction fetch front end: owns the fetch PC, issues reads to an external 1-cycle-latency synchronous instruction RAM, and predecodes each returned word to choose the next fetch PC.
- Buffers fetched instructions in a 2-entry queue toward the CCE decoder and supports redirect (mispredict recovery) from execute.
- Generalises prior predecode: parametrised PC width, field positions and prediction mode, plus a valid/yumi handshake.

---
 rtl/bp_cce_inst_fetch_pred.sv | 204 ++++++++++++++++++++
 tb/tb_bp_cce_inst_fetch_pred.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_inst_fetch_pred.sv
// ---------------------------------------------------------------------------
// bp_cce_inst_fetch_pred
//
// Instruction fetch front end for the CCE. Owns the fetch PC, issues reads to
// an external synchronous instruction RAM with one cycle of read latency, and
// predecodes each returned word to choose the next fetch PC. Fetched words are
// held in a 2-entry queue toward the decoder (valid/yumi handshake). A
// redirect from execute flushes everything and restarts fetch.
//
// Ports
//   clk_i              clock
//   reset_i            asynchronous active-high reset
//   fetch_en_i         permits new RAM reads
//   ram_v_o            RAM read strobe this cycle
//   ram_addr_o         RAM read address (always the next fetch PC)
//   ram_data_i         RAM read data, valid the cycle after ram_v_o
//   redirect_v_i       flush queue and in-flight read, restart fetch
//   redirect_pc_i      restart PC
//   inst_v_o           queue head valid
//   inst_o             head instruction (0 when empty)
//   inst_pc_o          head PC (0 when empty)
//   inst_pred_taken_o  head predicted taken (0 when empty)
//   inst_pred_pc_o     head predicted next PC (0 when empty)
//   inst_yumi_i        decoder consumes head; only legal while inst_v_o = 1
//
// Prediction modes (predict_mode_p)
//   0 : never taken
//   1 : taken iff branch flag and predict flag are both set
//   2 : taken iff branch flag is set
// ---------------------------------------------------------------------------
module bp_cce_inst_fetch_pred #(
  parameter int width_p        = 8,
  parameter int inst_width_p   = 48,
  parameter int branch_bit_p   = 0,
  parameter int predict_bit_p  = 1,
  parameter int target_lsb_p   = 2,
  parameter int predict_mode_p = 1,
  parameter int boot_pc_p      = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    fetch_en_i,
  output logic                    ram_v_o,
  output logic [width_p-1:0]      ram_addr_o,
  input  logic [inst_width_p-1:0] ram_data_i,
  input  logic                    redirect_v_i,
  input  logic [width_p-1:0]      redirect_pc_i,
  output logic                    inst_v_o,
  output logic [inst_width_p-1:0] inst_o,
  output logic [width_p-1:0]      inst_pc_o,
  output logic                    inst_pred_taken_o,
  output logic [width_p-1:0]      inst_pred_pc_o,
  input  logic                    inst_yumi_i
);

  localparam logic [width_p-1:0] boot_pc_lp = width_p'(boot_pc_p);

  // One queued instruction together with its predecode result.
  typedef struct packed {
    logic [inst_width_p-1:0] inst;
    logic [width_p-1:0]      pc;
    logic                    pred_taken;
    logic [width_p-1:0]      pred_pc;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [width_p-1:0] fetch_pc_r;     // next PC to fetch when nothing is in flight
  logic               inflight_r;     // a RAM read issued last cycle returns now
  logic [width_p-1:0] inflight_pc_r;  // PC of that read
  logic [1:0]         count_r;        // queue occupancy, 0..2
  entry_t             queue_r [2];    // slot 0 is always the head

  // -------------------------------------------------------------------------
  // Predecode of the returning word
  // -------------------------------------------------------------------------
  logic               pd_branch;
  logic               pd_predict;
  logic               pd_taken;
  logic [width_p-1:0] pd_target;
  logic [width_p-1:0] pd_pred_pc;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path through the case/if leaves it unassigned (no latch).
  always_comb begin
    pd_taken   = 1'b0;
    pd_branch  = ram_data_i[branch_bit_p];
    pd_predict = ram_data_i[predict_bit_p];
    pd_target  = ram_data_i[target_lsb_p +: width_p];
    case (predict_mode_p)
      0:       pd_taken = 1'b0;
      2:       pd_taken = pd_branch;
      default: pd_taken = pd_branch & pd_predict;
    endcase
    // Sequential successor wraps naturally at 2^width_p.
    pd_pred_pc = pd_taken ? pd_target : inflight_pc_r + width_p'(1);
  end

  // -------------------------------------------------------------------------
  // Issue / enqueue / dequeue decisions
  // -------------------------------------------------------------------------
  logic [width_p-1:0] next_pc;
  logic               yumi_ok;    // yumi qualified by a non-empty queue
  logic [1:0]         occupancy;  // count + in-flight after this cycle's yumi
  logic               issue;
  logic               enq;
  logic               deq;
  logic               wr_idx;     // slot the returning word is written into
  entry_t             enq_entry;

  always_comb begin
    // The word returning this cycle, once predecoded, names the next PC;
    // otherwise the held fetch PC does.
    next_pc   = inflight_r ? pd_pred_pc : fetch_pc_r;
    yumi_ok   = inst_yumi_i & (count_r != 2'd0);
    occupancy = count_r + {1'b0, inflight_r} - {1'b0, yumi_ok};

    // Issue only if the result is guaranteed a queue slot when it returns.
    // The yumi term makes this a combinational path from inst_yumi_i.
    issue = fetch_en_i & ~redirect_v_i & ~reset_i & (occupancy < 2'd2);

    enq = inflight_r & ~redirect_v_i;
    deq = yumi_ok & ~redirect_v_i;

    // With a dequeue the surviving entry moves to slot 0, so the tail slot is
    // the occupancy left after the dequeue.
    wr_idx = (count_r == 2'd2) | ((count_r == 2'd1) & ~deq);

    enq_entry.inst       = ram_data_i;
    enq_entry.pc         = inflight_pc_r;
    enq_entry.pred_taken = pd_taken;
    enq_entry.pred_pc    = pd_pred_pc;
  end

  assign ram_v_o    = issue;
  assign ram_addr_o = next_pc;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_r    <= boot_pc_lp;
      inflight_r    <= 1'b0;
      inflight_pc_r <= boot_pc_lp;
      count_r       <= 2'd0;
    end else if (redirect_v_i) begin
      // Redirect wins over everything: drop the queue, drop the returning
      // word and ignore any yumi this cycle.
      fetch_pc_r <= redirect_pc_i;
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (issue) begin
        inflight_r    <= 1'b1;
        inflight_pc_r <= next_pc;
      end else begin
        // No read this cycle: park the predicted PC so fetch resumes there.
        inflight_r <= 1'b0;
        fetch_pc_r <= next_pc;
      end
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  // -------------------------------------------------------------------------
  // Queue payload
  // -------------------------------------------------------------------------
  // NOTE: the payload slots carry no reset; count_r alone says which slots
  // hold live data, and the outputs are forced to zero while empty.
  always_ff @(posedge clk_i) begin
    if (deq && (count_r == 2'd2)) begin
      queue_r[0] <= queue_r[1];
    end
    if (enq) begin
      queue_r[wr_idx] <= enq_entry;
    end
  end

  // -------------------------------------------------------------------------
  // Head outputs
  // -------------------------------------------------------------------------
  assign inst_v_o          = (count_r != 2'd0);
  assign inst_o            = inst_v_o ? queue_r[0].inst       : '0;
  assign inst_pc_o         = inst_v_o ? queue_r[0].pc         : '0;
  assign inst_pred_taken_o = inst_v_o ? queue_r[0].pred_taken : 1'b0;
  assign inst_pred_pc_o    = inst_v_o ? queue_r[0].pred_pc    : '0;

  // -------------------------------------------------------------------------
  // Protocol checks (simulation)
  // -------------------------------------------------------------------------
  // The issue rule reserves a slot for every read, so a full queue can never
  // receive a word without also losing its head.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(enq && !deq && (count_r == 2'd2)));

  // The decoder may only consume a valid head.
  a_yumi_legal : assert property (@(posedge clk_i) disable iff (reset_i)
    inst_yumi_i |-> inst_v_o);

endmodule

// File: tb/tb_bp_cce_inst_fetch_pred.sv
// ---------------------------------------------------------------------------
// tb_bp_cce_inst_fetch_pred
//
// Directed and randomized checks of the fetch front end. The reference model
// tracks fetch as a list of issued-but-unconsumed PCs: a PC becomes visible
// at the head two cycles after its issue, a new read may issue while fewer
// than two are outstanding after the consumer's yumi, and the next fetch PC
// is the predicted successor of the last issued PC, computed from the
// instruction memory contents.
// ---------------------------------------------------------------------------
module tb_bp_cce_inst_fetch_pred;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        ram_v;
  logic [7:0]  ram_addr;
  logic [47:0] ram_data;
  logic        redirect_v;
  logic [7:0]  redirect_pc;
  logic        inst_v;
  logic [47:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_taken;
  logic [7:0]  inst_pred;
  logic        yumi;

  // Second instance in never-taken mode.
  logic        reset0;
  logic        fetch_en0;
  logic        ram_v0;
  logic [7:0]  ram_addr0;
  logic [47:0] ram_data0;
  logic        inst_v0;
  logic [47:0] inst0;
  logic [7:0]  inst_pc0;
  logic        inst_taken0;
  logic [7:0]  inst_pred0;
  logic        yumi0;
  logic        redirect_v0;
  logic [7:0]  redirect_pc0;

  logic [47:0] mem [256];

  int errors = 0;
  int checks = 0;

  bp_cce_inst_fetch_pred #(.predict_mode_p(1)) dut (
    .clk_i(clk), .reset_i(reset), .fetch_en_i(fetch_en),
    .ram_v_o(ram_v), .ram_addr_o(ram_addr), .ram_data_i(ram_data),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc),
    .inst_v_o(inst_v), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_pred_taken_o(inst_taken), .inst_pred_pc_o(inst_pred),
    .inst_yumi_i(yumi)
  );

  bp_cce_inst_fetch_pred #(.predict_mode_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset0), .fetch_en_i(fetch_en0),
    .ram_v_o(ram_v0), .ram_addr_o(ram_addr0), .ram_data_i(ram_data0),
    .redirect_v_i(redirect_v0), .redirect_pc_i(redirect_pc0),
    .inst_v_o(inst_v0), .inst_o(inst0), .inst_pc_o(inst_pc0),
    .inst_pred_taken_o(inst_taken0), .inst_pred_pc_o(inst_pred0),
    .inst_yumi_i(yumi0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAMs, one cycle read latency.
  always @(posedge clk) if (ram_v)  ram_data  <= mem[ram_addr];
  always @(posedge clk) if (ram_v0) ram_data0 <= mem[ram_addr0];

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] pc;
    int         cyc;
  } item_t;

  item_t      mq[$];
  logic [7:0] chain_pc;
  int         cyc;

  function automatic logic model_taken(input logic [7:0] pc, input int mode);
    logic [47:0] w;
    w = mem[pc];
    if (mode == 0) return 1'b0;
    if (mode == 2) return w[0];
    return w[0] & w[1];
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] pc, input int mode);
    logic [47:0] w;
    w = mem[pc];
    if (model_taken(pc, mode)) return w[9:2];
    return pc + 8'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of the outputs seen in the most recent step.
  logic       s_v, s_rv, s_taken;
  logic [7:0] s_addr, s_pc, s_pred;

  // One clock cycle, entered and left at a falling edge.
  // ymode: 0 = never consume, 1 = consume whenever valid, 2 = random.
  task automatic step(input logic fe, input logic rd, input logic [7:0] rpc, input int ymode);
    logic       exp_v;
    logic       exp_rv;
    logic [7:0] hpc;
    int         occ;
    fetch_en    = fe;
    redirect_v  = rd;
    redirect_pc = rpc;
    exp_v = (mq.size() > 0) && (mq[0].cyc <= cyc - 2);
    yumi  = exp_v && ((ymode == 1) || ((ymode == 2) && ($urandom_range(1, 0) == 1)));
    #1;
    s_v = inst_v; s_rv = ram_v; s_addr = ram_addr;
    s_pc = inst_pc; s_taken = inst_taken; s_pred = inst_pred;
    check("inst_v", inst_v, exp_v);
    if (exp_v) begin
      hpc = mq[0].pc;
      check("inst_pc", inst_pc, hpc);
      check("inst", inst, mem[hpc]);
      check("pred_taken", inst_taken, model_taken(hpc, 1));
      check("pred_pc", inst_pred, model_next(hpc, 1));
    end else begin
      check("inst_empty", inst, 0);
    end
    occ    = mq.size() - (yumi ? 1 : 0);
    exp_rv = fe && !rd && (occ < 2);
    check("ram_v", ram_v, exp_rv);
    if (exp_rv) check("ram_addr", ram_addr, chain_pc);
    if (rd) begin
      mq.delete();
      chain_pc = rpc;
    end else begin
      if (yumi) void'(mq.pop_front());
      if (exp_rv) begin
        mq.push_back('{pc: chain_pc, cyc: cyc});
        chain_pc = model_next(chain_pc, 1);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [63:0] r;
    logic [7:0]  a0[$];
    logic        seen3;
    logic        t3;
    logic [7:0]  p3;

    reset = 1'b1; reset0 = 1'b1;
    fetch_en = 1'b1; redirect_v = 1'b0; redirect_pc = 8'h00; yumi = 1'b0;
    fetch_en0 = 1'b0; redirect_v0 = 1'b0; redirect_pc0 = 8'h00; yumi0 = 1'b0;

    for (int i = 0; i < 256; i++) begin
      r = {$urandom(), $urandom()};
      mem[i] = r[47:0];
    end
    for (int i = 0; i < 3; i++) mem[i][0] = 1'b0;
    mem[3][0]   = 1'b1;
    mem[3][1]   = 1'b1;
    mem[3][9:2] = 8'h40;
    mem[8'hFF][0] = 1'b0;

    // Reset state, with fetch enabled during reset.
    #2;
    check("rst_ram_v", ram_v, 0);
    check("rst_inst_v", inst_v, 0);
    check("rst_inst", inst, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; chain_pc = 8'h00; mq.delete();

    // Sequential fetch then the taken branch at PC 3.
    step(1, 0, 0, 1); check("seq_rv0", s_rv, 1); check("seq_addr0", s_addr, 0); check("seq_v0", s_v, 0);
    step(1, 0, 0, 1); check("seq_addr1", s_addr, 1);
    step(1, 0, 0, 1); check("seq_addr2", s_addr, 2); check("seq_pc0", s_pc, 0);
    step(1, 0, 0, 1); check("seq_addr3", s_addr, 3); check("seq_pc1", s_pc, 1);
    step(1, 0, 0, 1); check("br_addr", s_addr, 8'h40); check("seq_pc2", s_pc, 2);
    step(1, 0, 0, 1); check("br_pc", s_pc, 3); check("br_taken", s_taken, 1); check("br_pred", s_pred, 8'h40);

    // Back-pressure: queue fills, reads stop, then resume on yumi.
    step(1, 0, 0, 0); check("bp_rv0", s_rv, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); check("bp_rv2", s_rv, 0); check("bp_v2", s_v, 1);
    step(1, 0, 0, 1); check("bp_resume", s_rv, 1);
    step(1, 0, 0, 1);

    // Redirect with a full queue, then with a read in flight, then wrap.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 8'h80, 0); check("rd_rv", s_rv, 0);
    step(1, 0, 0, 1); check("rd_v", s_v, 0); check("rd_rv1", s_rv, 1); check("rd_addr", s_addr, 8'h80);
    step(1, 1, 8'hFF, 1);
    step(1, 0, 0, 1); check("wrap_v", s_v, 0); check("wrap_addr0", s_addr, 8'hFF);
    step(1, 0, 0, 1); check("wrap_addr1", s_addr, 8'h00);
    step(1, 0, 0, 1); check("wrap_pc", s_pc, 8'hFF); check("wrap_pred", s_pred, 8'h00);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(9, 0) != 0), ($urandom_range(19, 0) == 0),
           8'($urandom_range(255, 0)), 2);
    end

    // Asynchronous reset mid-cycle while streaming.
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1);
    fetch_en = 1'b1; redirect_v = 1'b0; yumi = 1'b1;
    #1;
    check("pre_rst_rv", ram_v, 1);
    check("pre_rst_v", inst_v, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rv", ram_v, 0);
    check("async_v", inst_v, 0);
    yumi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete(); chain_pc = 8'h00;
    step(1, 0, 0, 1); check("boot_rv", s_rv, 1); check("boot_addr", s_addr, 0);
    fetch_en = 1'b0;

    // Never-taken instance: PC 3 is followed by PC 4.
    seen3 = 1'b0; t3 = 1'b1; p3 = 8'h00;
    reset0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      fetch_en0 = 1'b1;
      #1 yumi0 = inst_v0;
      #1;
      if (ram_v0) a0.push_back(ram_addr0);
      if (inst_v0 && (inst_pc0 == 8'd3)) begin
        seen3 = 1'b1; t3 = inst_taken0; p3 = inst_pred0;
      end
      @(negedge clk);
    end
    yumi0 = 1'b0;
    check("m0_addr3", a0[3], 3);
    check("m0_addr4", a0[4], 4);
    check("m0_seen3", seen3, 1);
    check("m0_taken", t3, 0);
    check("m0_pred", p3, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
